led_bank_arbiter: RTL and testbench
===================================

Name: led_bank_arbiter

Overview:
- Shares the board LED bank between NUM_REQ on-chip requesters (Nios II PIO, hardware pattern generators) using round-robin arbitration with a time quantum.
- Also debounces the slide switches and exports the clean switch values to the rest of the design.
- Sits between the top-level board pins (SW, LEDR) and the Nios system/fabric logic, on the 50 MHz MAX10 clock.

Parameters:
- NUM_REQ, 3, number of LED requesters (2..8)
- LED_W, 2, LED bank width
- SW_W, 2, switch bank width
- DB_CYCLES, 500000, consecutive stable cycles required before a debounced switch changes (10 ms at 50 MHz)
- QUANTUM_CYCLES, 5000000, maximum ownership time while another requester is waiting (100 ms)

Ports:
- MAX10_CLK1_50  in  1  system clock, 50 MHz
- reset_reset  in  1  asynchronous, active-high reset
- SW  in  SW_W  raw slide switches, asynchronous to clock
- sw_db  out  SW_W  debounced switch values
- req  in  NUM_REQ  level request per requester; held while ownership wanted
- led_data  in  NUM_REQ*LED_W  requester i drives bits [i*LED_W +: LED_W]
- grant  out  NUM_REQ  one-hot current owner, all zero when none
- owner_valid  out  1  high when grant is non-zero
- preempt  out  1  one-cycle pulse when an owner is revoked by quantum expiry
- LEDR  out  LED_W  registered LED bank drive

Behaviour:
- Reset, asynchronous and active-high: sw_db=0, grant=0, owner_valid=0, preempt=0, LEDR=0, last-owner pointer=NUM_REQ-1, quantum counter=0, debounce counters=0, synchronizers=0.
- Debounce, per bit:
  - Two-flop synchronizer, then a counter.
  - The counter clears whenever the synced value equals sw_db.
  - Otherwise the counter increments; when it reaches DB_CYCLES-1, sw_db takes the synced value and the counter clears.
  - A glitch shorter than DB_CYCLES resets the count and produces no change.
  - Latency from a stable SW edge to sw_db is DB_CYCLES+2 cycles.
- FSM states: IDLE, OWN, GAP.
  - IDLE:
    - If any req bit is set, grant the first set bit searching upward from (last_owner+1) mod NUM_REQ, with wrap-around.
    - Load the quantum counter with 0 and go to OWN. The grant is registered, visible the next cycle.
  - OWN:
    - LEDR <= owner's led_data slice every cycle (one-cycle latency).
    - The quantum counter increments only while another req bit is set; otherwise it holds at 0.
    - If the owner's req drops: clear grant, set last_owner=owner, go to GAP.
    - Else, if the counter reaches QUANTUM_CYCLES-1 with another req pending: pulse preempt, clear grant, set last_owner=owner, go to GAP.
    - Request drop takes priority over expiry when both occur in the same cycle (preempt stays low).
  - GAP:
    - One cycle with LEDR <= 0 and grant=0, then go to IDLE.
    - Arbitration restarts with the rotated pointer, so a re-requesting former owner is served last.
- Single requester with req held: it keeps ownership indefinitely; preempt never fires.
- req bits for non-owners may toggle freely; only the value sampled in IDLE matters.
- In IDLE, LEDR = 0.
- Reset mid-ownership: immediate return to the reset values; the pointer returns to NUM_REQ-1, so requester 0 wins first after reset.

Optional Feature:
- Macro: LED_ARB_SW_OVERRIDE_EN
- Defined:
  - While sw_db[SW_W-1]=1, LEDR <= sw_db[LED_W-1:0] (zero-extended or truncated to LED_W).
  - Arbitration is frozen: FSM state, grant and quantum counter hold; preempt stays 0.
  - Releasing the switch resumes OWN, and LEDR returns to the owner's data the next cycle.
- Undefined: the switch has no effect on LEDR; override logic is absent.

Decomposition:
- Package led_arb_pkg: FSM state enum (IDLE/OWN/GAP), localparam widths (clog2 of NUM_REQ, DB_CYCLES, QUANTUM_CYCLES), and a round-robin "next set bit after pointer" function.
- Sub-module sw_debounce: one bit, parameter DB_CYCLES, containing the synchronizer and counter; instantiated SW_W times in a generate loop.
- The arbiter FSM stays in the top module.

Test Plan:
Test parameters: DB_CYCLES=4, QUANTUM_CYCLES=8.
- Reset, then SW=2'b01 held 10 cycles → sw_db=2'b01 exactly 6 cycles after the edge. A 3-cycle pulse on SW[1] → sw_db[1] stays 0.
- req=3'b010, led_data[3:2]=2'b11 → grant=3'b010 one cycle later and LEDR=2'b11 on the following cycle. Drop req → one GAP cycle with LEDR=0, then IDLE.
- req=3'b111 held, reset pointer → grant sequence 001, 010, 100, 001.
  - Each ownership lasts 8 cycles, with a preempt pulse at each expiry and one GAP cycle between owners.
- Only req[2] held for 50 cycles → grant=3'b100 throughout, preempt never asserted.
- req[0] drops on the same cycle as quantum expiry with req[1] pending → preempt=0, next grant=3'b010.
- With LED_ARB_SW_OVERRIDE_EN: owner 0 active, SW[1] held stable.
  - Once sw_db=2'b10, LEDR=2'b10 and the grant stays frozen with no preempt.
  - Release SW → LEDR returns to led_data[1:0].

Source files
------------

// File: rtl/led_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_arb_pkg
// Purpose  : Shared types and helpers for the LED bank arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package led_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  localparam int MAX_REQ   = 8;
  localparam int REQ_IDX_W = 3;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit strictly after 'last', wrapping modulo n.
  function automatic logic [REQ_IDX_W-1:0] rr_next(
    input logic [MAX_REQ-1:0]   req,
    input logic [REQ_IDX_W-1:0] last,
    input int                   n
  );
    logic [REQ_IDX_W-1:0] pick;
    logic                 found;
    int                   idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = (int'(last) + k) % n;
      if (k <= n && !found && req[idx[REQ_IDX_W-1:0]]) begin
        pick  = idx[REQ_IDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_bank_arbiter_sw_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sw_debounce
// Purpose  : One-bit two-flop synchronizer followed by a stability counter.
// Revision : 1.0 - initial release
// ============================================================================
module sw_debounce
  import led_arb_pkg::*;
#(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_in,
  output logic sw_db
);

  localparam int CW = cnt_width(DB_CYCLES);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = sw_in;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sw_db = db_q;

endmodule
`default_nettype wire

// File: rtl/led_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : led_bank_arbiter
// Purpose  : Round-robin, time-quantum sharing of the LED bank plus switch
//            debouncing. Optional switch override: LED_ARB_SW_OVERRIDE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module led_bank_arbiter
  import led_arb_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int LED_W          = 2,
  parameter int SW_W           = 2,
  parameter int DB_CYCLES      = 500000,
  parameter int QUANTUM_CYCLES = 5000000
) (
  input  logic                     MAX10_CLK1_50,
  input  logic                     reset_reset,
  input  logic [SW_W-1:0]          SW,
  output logic [SW_W-1:0]          sw_db,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LED_W-1:0] led_data,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     owner_valid,
  output logic                     preempt,
  output logic [LED_W-1:0]         LEDR
);

  localparam int IDX_W = cnt_width(NUM_REQ);
  localparam int QW    = cnt_width(QUANTUM_CYCLES);

  for (genvar i = 0; i < SW_W; i++) begin : g_sw_db
    sw_debounce #(
      .DB_CYCLES (DB_CYCLES)
    ) u_db (
      .clk   (MAX10_CLK1_50),
      .rst   (reset_reset),
      .sw_in (SW[i]),
      .sw_db (sw_db[i])
    );
  end

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [QW-1:0]      qcnt_q, qcnt_d;
  logic               preempt_q, preempt_d;
  logic [LED_W-1:0]   ledr_q, ledr_d;
  logic               contended;
  logic [LED_W-1:0]   owner_led;

`ifdef LED_ARB_SW_OVERRIDE_EN
  logic [SW_W+LED_W-1:0] sw_ext;
  assign sw_ext = {{LED_W{1'b0}}, sw_db};
`endif

  assign owner_led = led_data[int'(owner_q)*LED_W +: LED_W];

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    last_d    = last_q;
    qcnt_d    = qcnt_q;
    preempt_d = 1'b0;
    ledr_d    = '0;
    contended = |(req & ~grant_q);
    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d          = IDX_W'(rr_next(MAX_REQ'(req), REQ_IDX_W'(last_q), NUM_REQ));
          grant_d          = '0;
          grant_d[owner_d] = 1'b1;
          qcnt_d           = '0;
          state_d          = OWN;
        end
      end
      OWN: begin
        // A dropped request wins over a simultaneous quantum expiry.
        if (!req[owner_q]) begin
          grant_d = '0;
          last_d  = owner_q;
          qcnt_d  = '0;
          state_d = GAP;
        end else if (contended && qcnt_q == QW'(QUANTUM_CYCLES - 1)) begin
          preempt_d = 1'b1;
          grant_d   = '0;
          last_d    = owner_q;
          qcnt_d    = '0;
          state_d   = GAP;
        end else begin
          ledr_d = owner_led;
          qcnt_d = contended ? qcnt_q + 1'b1 : '0;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
`ifdef LED_ARB_SW_OVERRIDE_EN
    // Switch override freezes arbitration and shows the switches instead.
    if (sw_db[SW_W-1]) begin
      state_d   = state_q;
      grant_d   = grant_q;
      owner_d   = owner_q;
      last_d    = last_q;
      qcnt_d    = qcnt_q;
      preempt_d = 1'b0;
      ledr_d    = sw_ext[LED_W-1:0];
    end
`endif
  end

  always_ff @(posedge MAX10_CLK1_50 or posedge reset_reset) begin
    if (reset_reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
      qcnt_q    <= '0;
      preempt_q <= 1'b0;
      ledr_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      qcnt_q    <= qcnt_d;
      preempt_q <= preempt_d;
      ledr_q    <= ledr_d;
    end
  end

  assign grant       = grant_q;
  assign owner_valid = |grant_q;
  assign preempt     = preempt_q;
  assign LEDR        = ledr_q;

endmodule
`default_nettype wire

// File: tb/tb_led_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_bank_arbiter
// Purpose  : Self-checking bench for led_bank_arbiter (DB_CYCLES=4, QUANTUM=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_bank_arbiter;

  localparam int NR = 3;
  localparam int LW = 2;
  localparam int SWW = 2;
  localparam int DB = 4;
  localparam int QC = 8;

  logic          clk;
  logic          rst;
  logic [SWW-1:0] SW;
  logic [SWW-1:0] sw_db;
  logic [NR-1:0]  req;
  logic [NR*LW-1:0] led_data;
  logic [NR-1:0]  grant;
  logic           owner_valid;
  logic           preempt;
  logic [LW-1:0]  LEDR;

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_on  = 0;

  led_bank_arbiter #(
    .NUM_REQ        (NR),
    .LED_W          (LW),
    .SW_W           (SWW),
    .DB_CYCLES      (DB),
    .QUANTUM_CYCLES (QC)
  ) dut (
    .MAX10_CLK1_50 (clk),
    .reset_reset   (rst),
    .SW            (SW),
    .sw_db         (sw_db),
    .req           (req),
    .led_data      (led_data),
    .grant         (grant),
    .owner_valid   (owner_valid),
    .preempt       (preempt),
    .LEDR          (LEDR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference model: owner index (-1 = none), pending gap, contended age.
  int           m_owner, m_last, m_age;
  bit           m_gap, m_pre, frozen;
  logic [LW-1:0] m_led;
  logic [SWW-1:0] m_db, s1, s2;
  int           run [SWW];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_last = NR - 1; m_age = 0; m_gap = 0; m_pre = 0;
      m_led = '0; m_db = '0; s1 = '0; s2 = '0;
      for (int b = 0; b < SWW; b++) run[b] = 0;
    end else begin
      m_pre  = 0;
      frozen = 0;
`ifdef LED_ARB_SW_OVERRIDE_EN
      frozen = m_db[SWW-1];
`endif
      if (frozen) begin
        m_led = m_db[LW-1:0];
      end else if (m_owner < 0) begin
        m_led = '0;
        if (m_gap) m_gap = 0;
        else if (req != 0) begin
          for (int k = NR; k >= 1; k--)
            if (req[(m_last + k) % NR]) m_owner = (m_last + k) % NR;
          m_age = 0;
        end
      end else begin
        bit others;
        others = (req & ~(NR'(1) << m_owner)) != 0;
        if (!req[m_owner] || (others && m_age == QC - 1)) begin
          m_pre   = req[m_owner];
          m_last  = m_owner;
          m_owner = -1;
          m_gap   = 1;
          m_led   = '0;
        end else begin
          m_led = led_data[m_owner*LW +: LW];
          m_age = others ? m_age + 1 : 0;
        end
      end
      for (int b = 0; b < SWW; b++) begin
        if (s2[b] != m_db[b]) begin
          run[b]++;
          if (run[b] == DB) begin m_db[b] = s2[b]; run[b] = 0; end
        end else run[b] = 0;
      end
      s2 = s1;
      s1 = SW;
    end
  end

  always @(negedge clk) begin
    if (cmp_on && !rst) begin
      int eg;
      eg = (m_owner < 0) ? 0 : (1 << m_owner);
      chk("cyc_grant", int'(grant), eg);
      chk("cyc_owner_valid", int'(owner_valid), (eg != 0) ? 1 : 0);
      chk("cyc_preempt", int'(preempt), int'(m_pre));
      chk("cyc_ledr", int'(LEDR), int'(m_led));
      chk("cyc_sw_db", int'(sw_db), int'(m_db));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ns, nl, cur, bad, npre;
    logic [NR-1:0] prev;
    int seqv [4];
    int lens [4];
    int pres [4];

    rst = 1; SW = '0; req = '0; led_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", int'(grant), 0);
    chk("rst_owner_valid", int'(owner_valid), 0);
    chk("rst_preempt", int'(preempt), 0);
    chk("rst_ledr", int'(LEDR), 0);
    chk("rst_sw_db", int'(sw_db), 0);
    @(negedge clk);
    rst = 0; cmp_on = 1;

    // Debounce latency and glitch rejection.
    SW = 2'b01;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (sw_db == 2'b01) begin lat = k; break; end
    end
    chk("db_latency", lat, 6);
    repeat (4) @(negedge clk);
    SW = 2'b11;
    repeat (3) @(negedge clk);
    SW = 2'b01;
    repeat (10) @(negedge clk);
    chk("db_glitch", int'(sw_db), 1);

    // Single owner, request drop, gap.
    led_data = 6'b00_11_00; req = 3'b010;
    @(posedge clk); #1;
    chk("t2_grant", int'(grant), 2);
    chk("t2_led_first", int'(LEDR), 0);
    @(posedge clk); #1;
    chk("t2_led", int'(LEDR), 3);
    @(negedge clk); req = '0;
    @(posedge clk); #1;
    chk("t2_gap_grant", int'(grant), 0);
    chk("t2_gap_led", int'(LEDR), 0);
    @(posedge clk); #1;
    chk("t2_idle_grant", int'(grant), 0);
    chk("t2_idle_led", int'(LEDR), 0);

    // Full contention after reset: rotation with quantum expiry.
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0; req = 3'b111; led_data = 6'b10_01_11;
    ns = 0; nl = 0; cur = 0; prev = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (grant != 0) begin
        if (prev == 0) begin
          if (ns < 4) seqv[ns] = int'(grant);
          ns++;
        end
        cur++;
      end else if (prev != 0) begin
        if (nl < 4) begin lens[nl] = cur; pres[nl] = int'(preempt); end
        nl++;
        cur = 0;
      end
      prev = grant;
    end
    chk("t3_count", (ns >= 4 && nl >= 3) ? 1 : 0, 1);
    if (ns >= 4 && nl >= 3) begin
      chk("t3_seq0", seqv[0], 1);
      chk("t3_seq1", seqv[1], 2);
      chk("t3_seq2", seqv[2], 4);
      chk("t3_seq3", seqv[3], 1);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("t3_len%0d", i), lens[i], 8);
        chk($sformatf("t3_pre%0d", i), pres[i], 1);
      end
    end

    // Lone requester keeps ownership.
    @(negedge clk); req = '0;
    repeat (4) @(negedge clk);
    req = 3'b100;
    bad = 0; npre = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (grant != 3'b100) bad++;
      if (preempt) npre++;
    end
    chk("t4_hold_bad_cycles", bad, 0);
    chk("t4_preempt_count", npre, 0);

    // Asynchronous reset mid-ownership.
    rst = 1; #1;
    chk("t4_rst_grant", int'(grant), 0);
    chk("t4_rst_ledr", int'(LEDR), 0);
    req = '0;

    // Drop coinciding with expiry.
    @(negedge clk); rst = 0; req = 3'b011;
    @(posedge clk);
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("t5_owner_before", int'(grant), 1);
    req = 3'b010;
    @(posedge clk); #1;
    chk("t5_preempt", int'(preempt), 0);
    chk("t5_gap_grant", int'(grant), 0);
    @(posedge clk);
    @(posedge clk); #1;
    chk("t5_next_grant", int'(grant), 2);

`ifdef LED_ARB_SW_OVERRIDE_EN
    // Switch override freezes owner 0 and drives the switches.
    @(negedge clk); rst = 1; req = '0;
    @(negedge clk); rst = 0; req = 3'b001; led_data = 6'b00_00_01; SW = 2'b10;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (sw_db == 2'b10) begin lat = k; break; end
    end
    chk("ovr_db_seen", (lat != 0) ? 1 : 0, 1);
    req = 3'b011;
    @(posedge clk); #1;
    chk("ovr_ledr", int'(LEDR), 2);
    bad = 0; npre = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (grant != 3'b001) bad++;
      if (preempt) npre++;
    end
    chk("ovr_frozen_bad", bad, 0);
    chk("ovr_preempt", npre, 0);
    SW = 2'b00;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (sw_db == 2'b00) begin lat = k; break; end
    end
    chk("ovr_release_seen", (lat != 0) ? 1 : 0, 1);
    @(posedge clk); #1;
    chk("ovr_ledr_resume", int'(LEDR), 1);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
